// File: rtl/sseg_banner_rotator.sv
// Rotating-banner source: stores a hex message and scrolls an 8-nibble circular
// window across it at a fixed step rate for the seven-segment display driver.
module sseg_banner_rotator #(
    parameter int MSG_LEN  = 16,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        dir,
    input  logic        restart,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [3:0]  wr_data,
    output logic [31:0] current_disp,
    output logic        step_pulse,
    output logic [3:0]  pos
);

    localparam int             PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [3:0]     POS_LAST = 4'(MSG_LEN - 1);
    localparam logic [4:0]     LEN5     = 5'(MSG_LEN);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] prescale, prescale_nx;
    logic [3:0]    pos_nx;
    logic          step;
    logic [3:0]    msg [16];
    logic [31:0]   window;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prescale   <= '0;
            pos        <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            prescale   <= prescale_nx;
            pos        <= pos_nx;
            step_pulse <= step;
        end
    end

    // Restart is applied last so it overrides a step landing on the same edge.
    always_comb begin
        state_nx    = state;
        prescale_nx = prescale;
        pos_nx      = pos;
        step        = 1'b0;
        case (state)
            IDLE: begin
                prescale_nx = '0;
                if (enable) state_nx = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_nx    = IDLE;
                    prescale_nx = '0;
                end else if (prescale == PS_LAST) begin
                    prescale_nx = '0;
                    step        = 1'b1;
                end else begin
                    prescale_nx = prescale + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (step) begin
            if (dir) pos_nx = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
            else     pos_nx = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
        end
        if (restart) begin
            pos_nx      = '0;
            prescale_nx = '0;
            step        = 1'b0;
        end
    end

    // pos < MSG_LEN and k < 8 <= MSG_LEN, so a single subtraction wraps the index.
    always_comb begin
        logic [4:0] idx;
        window = '0;
        for (int k = 0; k < 8; k++) begin
            idx = {1'b0, pos} + 5'(k);
            if (idx >= LEN5) idx = idx - LEN5;
            window[31-4*k -: 4] = msg[idx[3:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) msg[i] <= 4'h0;
            current_disp <= 32'h0;
        end else begin
            if (wr_en && ({1'b0, wr_addr} < LEN5)) msg[wr_addr] <= wr_data;
            current_disp <= window;
        end
    end

endmodule
